// File: rtl/mult_sequencer.sv
// Multi-cycle signed MULT sequencer for the EX stage: stalls the pipeline while a
// shift-add multiply runs over DATA_W iterations, then publishes the product on hi/lo.
module mult_sequencer #(
  parameter int unsigned DATA_W    = 32,
  parameter logic [3:0]  MULT_CODE = 4'd6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FIX,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [PROD_W-1:0] mcand, mcand_nxt;
  logic [DATA_W-1:0] mplier, mplier_nxt;
  logic [PROD_W-1:0] acc, acc_nxt;
  logic              neg, neg_nxt;
  logic [DATA_W-1:0] hi_nxt, lo_nxt;

  logic              start;
  logic [DATA_W-1:0] mag_a, mag_b;
  logic [PROD_W-1:0] acc_fixed;

  assign start = instr_valid && (alu_control == MULT_CODE);

  // Magnitudes as unsigned; the most negative value maps to 2^(DATA_W-1) naturally.
  assign mag_a = op_a[DATA_W-1] ? (~op_a + DATA_W'(1)) : op_a;
  assign mag_b = op_b[DATA_W-1] ? (~op_b + DATA_W'(1)) : op_b;

  // Sign correction applied once after the unsigned iterations.
  assign acc_fixed = neg ? (~acc + PROD_W'(1)) : acc;

  // Next-state and datapath update
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    acc_nxt    = acc;
    neg_nxt    = neg;
    hi_nxt     = hi;
    lo_nxt     = lo;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          mcand_nxt  = PROD_W'(mag_a);
          mplier_nxt = mag_b;
          neg_nxt    = op_a[DATA_W-1] ^ op_b[DATA_W-1];
          acc_nxt    = '0;
          cnt_nxt    = '0;
          state_nxt  = S_BUSY;
        end
      end
      S_BUSY: begin
        if (mplier[0]) begin
          acc_nxt = acc + mcand;
        end
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
        cnt_nxt    = cnt + CNT_W'(1);
        if (cnt == LAST_ITER) begin
          state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        acc_nxt   = acc_fixed;
        hi_nxt    = acc_fixed[PROD_W-1:DATA_W];
        lo_nxt    = acc_fixed[DATA_W-1:0];
        state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      acc    <= acc_nxt;
      neg    <= neg_nxt;
      hi     <= hi_nxt;
      lo     <= lo_nxt;
    end
  end

  // stall covers the start cycle so the MULT holds in EX until its result is ready.
  assign stall = ((state == S_IDLE) && start) || (state == S_BUSY) || (state == S_FIX);
  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);

endmodule

// File: tb/tb_mult_sequencer.sv
// Randomized self-checking bench for mult_sequencer; products come from a signed
// 64-bit arithmetic reference and control timing from the cycle schedule.
module tb_mult_sequencer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LAT    = DATA_W + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              instr_valid;
  logic [3:0]        alu_control;
  logic [DATA_W-1:0] op_a, op_b;
  logic              stall, busy, done;
  logic [DATA_W-1:0] hi, lo;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned done_cnt = 0;
  logic [DATA_W-1:0] exp_hi = '0;
  logic [DATA_W-1:0] exp_lo = '0;

  mult_sequencer #(.DATA_W(DATA_W), .MULT_CODE(4'd6)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .alu_control(alu_control),
    .op_a       (op_a),
    .op_b       (op_b),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    sa = $signed(a);
    sb = $signed(b);
    p  = sa * sb;
    return p;
  endfunction

  task automatic drive_idle();
    instr_valid = 1'b0;
    alu_control = 4'd0;
    op_a        = $urandom;
    op_b        = $urandom;
  endtask

  task automatic drive_garbage();
    instr_valid = 1'($urandom);
    alu_control = 4'($urandom);
    op_a        = $urandom;
    op_b        = $urandom;
  endtask

  // One full MULT: start in cycle 0, junk inputs afterwards, result in cycle LAT.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] p;
    p = ref_prod(a, b);
    @(negedge clk);
    instr_valid = 1'b1;
    alu_control = 4'd6;
    op_a        = a;
    op_b        = b;
    #1;
    chk($sformatf("%s c0 stall/busy/done", tag), 64'({stall, busy, done}), 64'(3'b100));
    for (int c = 1; c <= int'(LAT); c++) begin
      @(negedge clk);
      drive_garbage();
      #1;
      if (c < int'(LAT)) begin
        chk($sformatf("%s c%0d stall/busy/done", tag, c), 64'({stall, busy, done}), 64'(3'b110));
        if (c == 1 || c == int'(LAT) - 1 || (c % 8) == 0)
          chk($sformatf("%s c%0d hold hi:lo", tag, c), {hi, lo}, {exp_hi, exp_lo});
      end else begin
        chk($sformatf("%s done stall/busy/done", tag), 64'({stall, busy, done}), 64'(3'b011));
        chk($sformatf("%s product hi:lo", tag), {hi, lo}, p);
      end
    end
    exp_hi = p[63:32];
    exp_lo = p[31:0];
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    drive_idle();
    #1;
    chk($sformatf("%s idle stall/busy/done", tag), 64'({stall, busy, done}), 64'(3'b000));
    chk($sformatf("%s idle hi:lo", tag), {hi, lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    logic [31:0] da [8];
    logic [31:0] db [8];
    int unsigned d0;
    logic [31:0] ra, rb;

    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    #1;
    chk("reset stall/busy/done", 64'({stall, busy, done}), 64'(3'b000));
    chk("reset hi:lo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed corner cases
    da = '{32'd3, 32'hFFFF_FFFF, -32'sd7, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'd9, 32'h8000_0000};
    db = '{32'd5, 32'd1, -32'sd6, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd9, 32'd0};
    for (int i = 0; i < 8; i++) begin
      run_mult(da[i], db[i], $sformatf("dir%0d", i));
      if (i == 0) chk("3x5 lo literal", 64'(lo), 64'h0000_000F);
      if (i == 3) chk("min*min hi literal", 64'(hi), 64'h4000_0000);
      idle_check($sformatf("dir%0d", i));
    end

    // Non-MULT traffic must never stall or disturb hi/lo
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      instr_valid = (c % 2 == 0);
      alu_control = (c % 2 == 0) ? 4'd2 : 4'd6;
      op_a        = $urandom;
      op_b        = $urandom;
      #1;
      chk($sformatf("nomult c%0d ctl", c), 64'({stall, busy, done}), 64'(3'b000));
      if (c % 10 == 9) chk($sformatf("nomult c%0d hi:lo", c), {hi, lo}, {exp_hi, exp_lo});
    end

    // Reset in the middle of a multiply discards it
    @(negedge clk);
    instr_valid = 1'b1;
    alu_control = 4'd6;
    op_a        = 32'd123;
    op_b        = 32'd456;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      drive_garbage();
      if (c == 10) rst = 1'b1;
    end
    #1;
    chk("midrst c10 ctl", 64'({stall, busy, done}), 64'(3'b110));
    d0 = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    #1;
    exp_hi = '0;
    exp_lo = '0;
    chk("midrst after ctl", 64'({stall, busy, done}), 64'(3'b000));
    chk("midrst after hi:lo", {hi, lo}, 64'd0);
    repeat (40) @(negedge clk);
    chk("midrst no done", 64'(done_cnt - d0), 64'd0);
    run_mult(32'd2, 32'd3, "post-rst");
    chk("post-rst lo literal", 64'(lo), 64'd6);
    idle_check("post-rst");

    // Back-to-back
    d0 = done_cnt;
    run_mult(32'd4, 32'd4, "b2b1");
    run_mult(32'd5, 32'd5, "b2b2");
    idle_check("b2b");
    chk("b2b done pulses", 64'(done_cnt - d0), 64'd2);
    chk("b2b lo literal", 64'(lo), 64'd25);

    // Random multiplies with random idle gaps
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 6 == 1) ra = 32'h8000_0000;
      if (i % 6 == 2) rb = 32'hFFFF_FFFF;
      if (i % 6 == 3) ra = 32'($urandom_range(0, 15));
      if (i % 6 == 4) rb = 32'h7FFF_FFFF;
      run_mult(ra, rb, $sformatf("rnd%0d", i));
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) idle_check($sformatf("rnd%0d gap%0d", i, g));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
